// File: rtl/fifo_link_pkg.sv
// Shared types and helpers for the credit-flow-controlled FIFO link.
package fifo_link_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} link_state_t;

    function automatic int credit_width(int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/fifo_if_t.sv
// FWFT FIFO read-side bundle: head word, head valid and pop strobe.
interface fifo_if_t #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] data;
    logic             data_vld;
    logic             read;

    modport slave  (input data, input data_vld, output read);
    modport master (output data, output data_vld, input read);
endinterface

// File: rtl/pipe_delay_line.sv
// Valid+data shift chain of LEVEL stages; only the valid bits and stage 0 data are reset.
module pipe_delay_line #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LEVEL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [LEVEL-1:0] vld_q;
    logic [WIDTH-1:0] head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < LEVEL; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Stage 0 reset value flushes zeros down the unreset tail while rst_n is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
        end else if (in_vld) begin
            head_q <= in_data;
        end
    end

    generate
        if (LEVEL == 1) begin : g_single
            assign out_data = head_q;
        end else begin : g_chain
            logic [WIDTH-1:0] tail_q [LEVEL-1];

            always_ff @(posedge clk) begin
                tail_q[0] <= head_q;
                for (int i = 1; i < LEVEL - 1; i++) begin
                    tail_q[i] <= tail_q[i-1];
                end
            end

            assign out_data = tail_q[LEVEL-2];
        end
    endgenerate

    assign out_vld = vld_q[LEVEL-1];
    assign busy    = |vld_q;

endmodule

// File: rtl/fifo_credit_writer.sv
// Credit-flow-controlled transmit end of a pipelined FIFO link, with flush handshake.
// Define FIFO_CREDIT_CHECK_EN to add the sticky credit_err overflow flag and pop assertion.
module fifo_credit_writer
    import fifo_link_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 64,
    parameter int unsigned  PIPE_LEVEL = 3,
    parameter int unsigned  CREDITS    = 8,
    localparam int unsigned CNT_W      = credit_width(CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_if_t.slave               s_fifo,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_vld,
    input  logic                  credit_in,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [CNT_W-1:0]      credits
`ifdef FIFO_CREDIT_CHECK_EN
    ,
    output logic                  credit_err
`endif
);

    localparam logic [CNT_W-1:0] CREDITS_FULL = CNT_W'(CREDITS);

    link_state_t      state_q, state_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             flush_done_q;
    logic             send;
    logic             pipe_busy;

    // rst_n term keeps the pop strobe low while reset is held.
    assign send = rst_n && (state_q == RUN) && !flush_req && s_fifo.data_vld &&
                  (credits_q != '0);
    assign s_fifo.read = send;

    always_comb begin
        credits_d = credits_q;
        if (send && !credit_in) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (credit_in && !send && (credits_q != CREDITS_FULL)) begin
            credits_d = credits_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!flush_req) begin
                    state_d = RUN;
                end else if ((credits_q == CREDITS_FULL) && !pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!flush_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            credits_q    <= CREDITS_FULL;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            flush_done_q <= (state_d == DONE);
        end
    end

    pipe_delay_line #(
        .WIDTH (DATA_WIDTH),
        .LEVEL (PIPE_LEVEL)
    ) u_fwd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (send),
        .in_data  (s_fifo.data),
        .out_vld  (m_vld),
        .out_data (m_data),
        .busy     (pipe_busy)
    );

    assign credits    = credits_q;
    assign flush_done = flush_done_q;

`ifdef FIFO_CREDIT_CHECK_EN
    logic credit_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err_q <= 1'b0;
        end else if (credit_in && (credits_q == CREDITS_FULL)) begin
            credit_err_q <= 1'b1;
        end
    end

    assign credit_err = credit_err_q;

    pop_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        s_fifo.read |-> s_fifo.data_vld);
`endif

endmodule
